// File: rtl/bus_input_reader.sv
// Bus-mapped input peripheral: synchronizes and debounces slide switches and push
// buttons and exposes levels plus sticky key-press events as four read registers.
module bus_input_reader #(
    parameter int ADDRESS           = 0,
    parameter int BUS_ADDR_DATA_LEN = 16,
    parameter int DEBOUNCE_CYCLES   = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         rd,
    input  logic                         wr,
    input  logic [7:0]                   bus_in,
    output logic [7:0]                   bus_out,
    input  logic [15:0]                  SW,
    input  logic [3:0]                   KEY
);

    localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] LP_LAST = PW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BUS_ADDR_DATA_LEN:0] LP_LO = (BUS_ADDR_DATA_LEN + 1)'(ADDRESS);
    localparam logic [BUS_ADDR_DATA_LEN:0] LP_HI = (BUS_ADDR_DATA_LEN + 1)'(ADDRESS + 4);

    logic [19:0]   w_raw;
    logic [19:0]   r_sync1;
    logic [19:0]   r_sync2;
    logic [19:0]   r_samp;
    logic [19:0]   r_stable;
    logic [19:0]   w_agree;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic [3:0]    w_keyStable;
    logic [3:0]    r_keyStableD;
    logic [3:0]    w_keyRise;
    logic [3:0]    r_evt;
    logic [3:0]    w_evtClr;
    logic          w_sel;
    logic          w_selEvt;
    logic [7:0]    w_readData;
    logic          w_unusedBusIn;

    // Keys are inverted at the pin so every conditioned bit reads 1 when active.
    assign w_raw = {~KEY, SW};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == LP_LAST);

    // A level is accepted only when it matches on two consecutive ticks.
    assign w_agree = ~(r_sync2 ^ r_samp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp   <= '0;
            r_stable <= '0;
        end else if (w_tick) begin
            r_samp   <= r_sync2;
            r_stable <= (r_stable & ~w_agree) | (r_sync2 & w_agree);
        end
    end

    assign w_keyStable = r_stable[19:16];
    assign w_keyRise   = w_keyStable & ~r_keyStableD;

    assign w_sel    = ({1'b0, addr} >= LP_LO) && ({1'b0, addr} < LP_HI);
    assign w_selEvt = w_sel && (addr[1:0] == 2'd3);

    // Clear-on-read and write-1-to-clear combine; a simultaneous rise still wins.
    assign w_evtClr = ({4{rd && w_selEvt}}) | ({4{wr && w_selEvt}} & bus_in[3:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_keyStableD <= '0;
            r_evt        <= '0;
        end else begin
            r_keyStableD <= w_keyStable;
            r_evt        <= (r_evt & ~w_evtClr) | w_keyRise;
        end
    end

    always_comb begin
        w_readData = 8'h00;
        case (addr[1:0])
            2'd0:    w_readData = r_stable[7:0];
            2'd1:    w_readData = r_stable[15:8];
            2'd2:    w_readData = {4'b0, w_keyStable};
            default: w_readData = {4'b0, r_evt};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_out <= 8'h00;
        end else if (rd && w_sel) begin
            bus_out <= w_readData;
        end else begin
            bus_out <= 8'h00;
        end
    end

    assign w_unusedBusIn = ^bus_in[7:4];

endmodule

// File: tb/tb_bus_input_reader.sv
// Scoreboard bench for bus_input_reader: reads push expected bytes, a monitor
// compares bus_out every cycle against the queue head or against idle zero.
module tb_bus_input_reader;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic [15:0] SW;
    logic [3:0]  KEY;

    int          totalChecks;
    int          badChecks;
    int          cyc;
    logic [7:0]  expQ[$];
    string       tagQ[$];

    bus_input_reader #(
        .ADDRESS          (16'h20),
        .BUS_ADDR_DATA_LEN(16),
        .DEBOUNCE_CYCLES  (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .rd     (rd),
        .wr     (wr),
        .bus_in (bus_in),
        .bus_out(bus_out),
        .SW     (SW),
        .KEY    (KEY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset release; the prescaler phase follows from it.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %02h want %02h at %0t", tag, observed, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        logic  pend;
        string tag;
        pend = rd && !rst;
        #1;
        if (pend) begin
            if (expQ.size() == 0) begin
                checkOutput("noexp", 8'(expQ.size()), 8'd1);
            end else begin
                tag = tagQ.pop_front();
                checkOutput(tag, bus_out, expQ.pop_front());
            end
        end else begin
            checkOutput("idle", bus_out, 8'h00);
        end
    end

    task automatic applyStimulus(input logic doRd, input logic doWr, input logic [15:0] a,
                                 input logic [7:0] d, input logic [7:0] expRd, input string tag);
        @(negedge clk);
        rd     = doRd;
        wr     = doWr;
        addr   = a;
        bus_in = d;
        if (doRd) begin
            expQ.push_back(expRd);
            tagQ.push_back(tag);
        end
    endtask

    task automatic busRead(input logic [15:0] a, input logic [7:0] expRd, input string tag);
        applyStimulus(1'b1, 1'b0, a, 8'h00, expRd, tag);
    endtask

    task automatic busWrite(input logic [15:0] a, input logic [7:0] d);
        applyStimulus(1'b0, 1'b1, a, d, 8'h00, "");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rd = 1'b0;
            wr = 1'b0;
        end
    endtask

    task automatic setInputs(input logic [15:0] sw, input logic [3:0] key);
        @(negedge clk);
        rd  = 1'b0;
        wr  = 1'b0;
        SW  = sw;
        KEY = key;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int t2;
        int guard;
        totalChecks = 0;
        badChecks   = 0;
        rst    = 1'b1;
        rd     = 1'b0;
        wr     = 1'b0;
        addr   = 16'h0;
        bus_in = 8'h00;
        SW     = 16'h0000;
        KEY    = 4'hF;
        idle(3);
        rst = 1'b0;

        // Reset mid-run with inputs held and events pending
        setInputs(16'hFFFF, 4'h0);
        idle(12);
        busRead(16'h22, 8'h0F, "preKeys");
        busRead(16'h20, 8'hFF, "preSwLo");
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        busRead(16'h20, 8'h00, "rstSwLo");
        idle(1);
        busRead(16'h21, 8'h00, "rstSwHi");
        idle(1);
        busRead(16'h22, 8'h00, "rstKeys");
        idle(1);
        busRead(16'h23, 8'h00, "rstEvt");
        idle(12);
        busRead(16'h23, 8'h0F, "heldEvt");
        busRead(16'h20, 8'hFF, "heldSw");
        setInputs(16'h0000, 4'hF);
        idle(12);
        busRead(16'h22, 8'h00, "relKeys");
        busRead(16'h23, 8'h00, "relEvt");
        busRead(16'h20, 8'h00, "relSw");

        // Switch path, selection boundaries, ignored write
        setInputs(16'hA55A, 4'hF);
        idle(12);
        busRead(16'h20, 8'h5A, "swLo");
        busRead(16'h21, 8'hA5, "swHi");
        busRead(16'h24, 8'h00, "above");
        busRead(16'h1F, 8'h00, "below");
        busWrite(16'h20, 8'hFF);
        busRead(16'h20, 8'h5A, "wrIgnored");
        setInputs(16'h0000, 4'hF);

        // Debounce: short glitch rejected, long press accepted
        setInputs(16'h0000, 4'b1011);
        idle(2);
        setInputs(16'h0000, 4'hF);
        idle(12);
        busRead(16'h22, 8'h00, "glitchKeys");
        busRead(16'h23, 8'h00, "glitchEvt");
        setInputs(16'h0000, 4'b1011);
        idle(12);
        busRead(16'h22, 8'h04, "holdKeys");
        busRead(16'h23, 8'h04, "holdEvt");
        setInputs(16'h0000, 4'hF);
        idle(12);

        // Event sticky and clear-on-read
        setInputs(16'h0000, 4'b1110);
        idle(12);
        setInputs(16'h0000, 4'hF);
        idle(12);
        busRead(16'h23, 8'h01, "evt0");
        busRead(16'h23, 8'h00, "evt0Clr");
        busRead(16'h22, 8'h00, "evt0Keys");

        // Write-1-to-clear, ignored write to offset 2, read+write together
        setInputs(16'h0000, 4'b1100);
        idle(12);
        setInputs(16'h0000, 4'hF);
        idle(12);
        busWrite(16'h22, 8'hFF);
        busWrite(16'h23, 8'h02);
        busRead(16'h23, 8'h01, "w1c");
        setInputs(16'h0000, 4'b1100);
        idle(12);
        setInputs(16'h0000, 4'hF);
        idle(12);
        applyStimulus(1'b1, 1'b1, 16'h23, 8'h01, 8'h03, "rdWr");
        busRead(16'h23, 8'h00, "rdWrAfter");

        // Read in the exact cycle evt[3] sets
        @(negedge clk);
        rd  = 1'b0;
        wr  = 1'b0;
        KEY = 4'b0111;
        c0  = cyc;
        t2  = ((c0 + 6) / 4) * 4 + 4;
        guard = 0;
        while (cyc < t2 - 1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        busRead(16'h23, 8'h00, "evtEdge");
        busRead(16'h23, 8'h08, "evtAfter");
        setInputs(16'h0000, 4'hF);
        idle(12);
        busRead(16'h22, 8'h00, "k3Rel");

        // Back-to-back reads over the whole map
        setInputs(16'h3CC3, 4'b1101);
        idle(12);
        busRead(16'h20, 8'hC3, "b2bSwLo");
        busRead(16'h21, 8'h3C, "b2bSwHi");
        busRead(16'h22, 8'h02, "b2bKeys");
        busRead(16'h23, 8'h02, "b2bEvt");
        idle(3);
        setInputs(16'h0000, 4'hF);
        idle(12);
        busRead(16'h23, 8'h00, "b2bEvtClr");
        idle(4);

        checkOutput("drain", 8'(expQ.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
